// File: rtl/branch_pkg.sv
// Shared encodings for the control-transfer resolution controller:
// op codes, branch funct3 values and FSM state encoding.
package branch_pkg;

  localparam logic [1:0] OP_BR   = 2'b00;
  localparam logic [1:0] OP_JAL  = 2'b01;
  localparam logic [1:0] OP_JALR = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CMP      = 2'd1,
    ST_RESOLVE  = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

endpackage

// File: rtl/branch_cmp.sv
// Registered operand comparator; outputs update only on cycles where en is high.
module branch_cmp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             lt_s,
  output logic             lt_u
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eq   <= 1'b0;
      lt_s <= 1'b0;
      lt_u <= 1'b0;
    end else if (en) begin
      eq   <= (a == b);
      lt_s <= ($signed(a) < $signed(b));
      lt_u <= (a < b);
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Resolves one branch/JAL/JALR at a time: capture, compare, decide, then
// redirect fetch and pulse flush/done.
//
// state       | meaning
// ST_IDLE     | ready for a new instruction; accepts on req_valid
// ST_CMP      | comparator and target registers load
// ST_RESOLVE  | taken/illegal/misalign decision
// ST_REDIRECT | holding redirect until fetch accepts
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int IALIGN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_rs1,
  input  logic [WIDTH-1:0] req_rs2,
  input  logic [WIDTH-1:0] req_pc,
  input  logic [WIDTH-1:0] req_imm,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] link_addr,
  output logic             taken,
  output logic             flush,
  output logic             done,
  output logic             misalign,
  output logic             illegal
);

  state_t state, state_nxt;

  logic [1:0]       op_q;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] rs1_q, rs2_q, pc_q, imm_q, target_q, target_nxt;
  logic             eq, lt_s, lt_u;
  logic             cond, is_illegal, is_taken, misaligned;
  logic             accept, rpc_load;
  logic             done_nxt, flush_nxt, misalign_nxt, illegal_nxt, taken_nxt, rv_nxt;

  branch_cmp #(.WIDTH(WIDTH)) u_cmp (
    .clk  (clk),
    .rst  (rst),
    .en   (state == ST_CMP),
    .a    (rs1_q),
    .b    (rs2_q),
    .eq   (eq),
    .lt_s (lt_s),
    .lt_u (lt_u)
  );

  assign req_ready  = (state == ST_IDLE);
  assign target_nxt = (op_q == OP_JALR) ? ((rs1_q + imm_q) & ~WIDTH'(1)) : (pc_q + imm_q);

  always_comb begin
    cond = 1'b0;
    case (f3_q)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = !eq;
      F3_BLT:  cond = lt_s;
      F3_BGE:  cond = !lt_s;
      F3_BLTU: cond = lt_u;
      F3_BGEU: cond = !lt_u;
      default: cond = 1'b0;
    endcase
    is_illegal = (op_q == 2'b11) ||
                 ((op_q == OP_BR) && ((f3_q == 3'b010) || (f3_q == 3'b011)));
    is_taken   = (op_q != OP_BR) || cond;
    if (IALIGN == 4) misaligned = |target_q[1:0];
    else             misaligned = target_q[0];
  end

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    rpc_load     = 1'b0;
    done_nxt     = 1'b0;
    flush_nxt    = 1'b0;
    misalign_nxt = 1'b0;
    illegal_nxt  = 1'b0;
    taken_nxt    = taken;
    rv_nxt       = redirect_valid;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = ST_CMP;
        end
      end
      ST_CMP: state_nxt = ST_RESOLVE;
      ST_RESOLVE: begin
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
        if (is_illegal) begin
          illegal_nxt = 1'b1;
          taken_nxt   = 1'b0;
        end else if (!is_taken) begin
          taken_nxt = 1'b0;
        end else if (misaligned) begin
          taken_nxt    = 1'b1;
          misalign_nxt = 1'b1;
        end else begin
          taken_nxt = 1'b1;
          done_nxt  = 1'b0;
          rv_nxt    = 1'b1;
          rpc_load  = 1'b1;
          state_nxt = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          rv_nxt    = 1'b0;
          flush_nxt = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      op_q           <= '0;
      f3_q           <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      pc_q           <= '0;
      imm_q          <= '0;
      target_q       <= '0;
      link_addr      <= '0;
      redirect_pc    <= '0;
      redirect_valid <= 1'b0;
      taken          <= 1'b0;
      flush          <= 1'b0;
      done           <= 1'b0;
      misalign       <= 1'b0;
      illegal        <= 1'b0;
    end else begin
      state          <= state_nxt;
      redirect_valid <= rv_nxt;
      taken          <= taken_nxt;
      flush          <= flush_nxt;
      done           <= done_nxt;
      misalign       <= misalign_nxt;
      illegal        <= illegal_nxt;
      if (accept) begin
        op_q      <= req_op;
        f3_q      <= req_funct3;
        rs1_q     <= req_rs1;
        rs2_q     <= req_rs2;
        pc_q      <= req_pc;
        imm_q     <= req_imm;
        link_addr <= req_pc + WIDTH'(4);
      end
      if (state == ST_CMP) target_q <= target_nxt;
      if (rpc_load)        redirect_pc <= target_q;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: timing of redirect/flush/done and outcomes.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_rs1 = '0, req_rs2 = '0, req_pc = '0, req_imm = '0;
  logic        redirect_valid;
  logic        redirect_ready = 1'b1;
  logic [31:0] redirect_pc, link_addr;
  logic        taken, flush, done, misalign, illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.WIDTH(32), .IALIGN(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_funct3(req_funct3), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_pc(req_pc), .req_imm(req_imm),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .link_addr(link_addr), .taken(taken),
    .flush(flush), .done(done), .misalign(misalign), .illegal(illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request starting at a sample point in IDLE; returns 1ns after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [2:0] f3,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] pc, input logic [31:0] imm);
    req_op = op; req_funct3 = f3; req_rs1 = rs1; req_rs2 = rs2;
    req_pc = pc; req_imm = imm; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    total++; if ({redirect_valid, taken, flush, done, misalign, illegal} !== 6'b0) begin bad++;
      $display("FAIL reset_flags got=%b exp=000000", {redirect_valid, taken, flush, done, misalign, illegal}); end
    total++; if ({redirect_pc, link_addr} !== 64'h0) begin bad++;
      $display("FAIL reset_regs got=%h/%h exp=0/0", redirect_pc, link_addr); end
    #20 rst = 1'b0;
    step();
  endtask

  task automatic test_beq();
    redirect_ready = 1'b1;
    issue(2'b00, 3'b000, 32'h10, 32'h10, 32'h100, 32'h20);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL beq_busy got=%b exp=0", req_ready); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL beq_early_done got=%b exp=0", done); end
    step();
    total++; if (redirect_valid !== 1'b1) begin bad++; $display("FAIL beq_rv got=%b exp=1", redirect_valid); end
    total++; if (redirect_pc !== 32'h120) begin bad++; $display("FAIL beq_rpc got=%h exp=00000120", redirect_pc); end
    total++; if (link_addr !== 32'h104) begin bad++; $display("FAIL beq_link got=%h exp=00000104", link_addr); end
    total++; if ({flush, done} !== 2'b00) begin bad++; $display("FAIL beq_early_flush got=%b exp=00", {flush, done}); end
    step();
    total++; if ({redirect_valid, flush, done, taken} !== 4'b0111) begin bad++;
      $display("FAIL beq_finish got=%b exp=0111", {redirect_valid, flush, done, taken}); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL beq_ready got=%b exp=1", req_ready); end
    step();
    total++; if ({flush, done} !== 2'b00) begin bad++; $display("FAIL beq_pulse_len got=%b exp=00", {flush, done}); end
  endtask

  task automatic test_blt_bltu();
    issue(2'b00, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40);
    step(); step();
    total++; if ({redirect_valid, taken} !== 2'b11) begin bad++; $display("FAIL blt_taken got=%b exp=11", {redirect_valid, taken}); end
    total++; if (redirect_pc !== 32'h240) begin bad++; $display("FAIL blt_rpc got=%h exp=00000240", redirect_pc); end
    step();
    total++; if ({flush, done} !== 2'b11) begin bad++; $display("FAIL blt_flush got=%b exp=11", {flush, done}); end
    issue(2'b00, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h40);
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL bltu_early_done got=%b exp=0", done); end
    step();
    total++; if ({done, taken, flush, redirect_valid} !== 4'b1000) begin bad++;
      $display("FAIL bltu_nt got=%b exp=1000", {done, taken, flush, redirect_valid}); end
    total++; if (link_addr !== 32'h304) begin bad++; $display("FAIL bltu_link got=%h exp=00000304", link_addr); end
    step();
    total++; if ({done, redirect_valid, flush} !== 3'b000) begin bad++;
      $display("FAIL bltu_after got=%b exp=000", {done, redirect_valid, flush}); end
  endtask

  task automatic test_jalr_misalign();
    issue(2'b10, 3'b000, 32'h203, 32'h0, 32'h500, 32'h0);
    step();
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL jalr_rv_mid got=%b exp=0", redirect_valid); end
    step();
    total++; if ({misalign, done, taken, redirect_valid} !== 4'b1110) begin bad++;
      $display("FAIL jalr_misalign got=%b exp=1110", {misalign, done, taken, redirect_valid}); end
    total++; if (link_addr !== 32'h504) begin bad++; $display("FAIL jalr_link got=%h exp=00000504", link_addr); end
    step();
    total++; if ({misalign, done, redirect_valid, flush} !== 4'b0000) begin bad++;
      $display("FAIL jalr_after got=%b exp=0000", {misalign, done, redirect_valid, flush}); end
  endtask

  task automatic test_redirect_stall();
    redirect_ready = 1'b0;
    issue(2'b00, 3'b001, 32'h1, 32'h2, 32'h400, 32'h40);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      total++; if ({redirect_valid, req_ready, flush, done} !== 4'b1000) begin bad++;
        $display("FAIL stall_flags[%0d] got=%b exp=1000", i, {redirect_valid, req_ready, flush, done}); end
      total++; if (redirect_pc !== 32'h440) begin bad++; $display("FAIL stall_rpc[%0d] got=%h exp=00000440", i, redirect_pc); end
      if (i < 4) step();
    end
    redirect_ready = 1'b1;
    step();
    total++; if ({redirect_valid, flush, done, taken} !== 4'b0111) begin bad++;
      $display("FAIL stall_release got=%b exp=0111", {redirect_valid, flush, done, taken}); end
  endtask

  task automatic test_back_to_back();
    redirect_ready = 1'b1;
    issue(2'b00, 3'b010, 32'h5, 32'h5, 32'h600, 32'h8);
    step(); step();
    total++; if ({illegal, done, taken, redirect_valid} !== 4'b1100) begin bad++;
      $display("FAIL illegal_flags got=%b exp=1100", {illegal, done, taken, redirect_valid}); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL illegal_ready got=%b exp=1", req_ready); end
    issue(2'b01, 3'b000, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h20);
    total++; if ({req_ready, illegal, done} !== 3'b000) begin bad++;
      $display("FAIL b2b_accept got=%b exp=000", {req_ready, illegal, done}); end
    step(); step();
    total++; if ({redirect_valid, taken} !== 2'b11) begin bad++; $display("FAIL jal_taken got=%b exp=11", {redirect_valid, taken}); end
    total++; if (redirect_pc !== 32'h10) begin bad++; $display("FAIL jal_wrap got=%h exp=00000010", redirect_pc); end
    total++; if (link_addr !== 32'hFFFF_FFF4) begin bad++; $display("FAIL jal_link got=%h exp=fffffff4", link_addr); end
    step();
    total++; if ({flush, done} !== 2'b11) begin bad++; $display("FAIL jal_flush got=%b exp=11", {flush, done}); end
  endtask

  task automatic test_reset_mid();
    redirect_ready = 1'b0;
    issue(2'b01, 3'b000, 32'h0, 32'h0, 32'h700, 32'h100);
    step(); step();
    total++; if (redirect_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b exp=1", redirect_valid); end
    rst = 1'b1;
    #1;
    total++; if ({redirect_valid, taken, flush, done, req_ready} !== 5'b00001) begin bad++;
      $display("FAIL rstmid_async got=%b exp=00001", {redirect_valid, taken, flush, done, req_ready}); end
    total++; if ({redirect_pc, link_addr} !== 64'h0) begin bad++;
      $display("FAIL rstmid_regs got=%h/%h exp=0/0", redirect_pc, link_addr); end
    redirect_ready = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if ({flush, done, redirect_valid, req_ready} !== 4'b0001) begin bad++;
        $display("FAIL rstmid_after[%0d] got=%b exp=0001", i, {flush, done, redirect_valid, req_ready}); end
    end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_blt_bltu();
    test_jalr_misalign();
    test_redirect_stall();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequences resolution of one control-transfer instruction (conditional branch, JAL, JALR) from issue to fetch redirect.
- Accepts the operands through a valid/ready handshake and runs them through a registered comparator.
- Computes the branch target and drives a redirect handshake toward fetch, followed by a pipeline flush pulse.
- Sits between decode/issue and the fetch PC mux; one instruction in flight at a time.

Parameters:
- WIDTH, 32, data/address width.
- IALIGN, 4, instruction alignment in bytes (4 checks target[1:0]; 2 checks target[0]).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  issue has a control-transfer instruction
- req_ready  out  1  controller can accept (high only in IDLE)
- req_op  in  2  00 branch, 01 JAL, 10 JALR, 11 reserved
- req_funct3  in  3  branch condition (RV32I encoding)
- req_rs1  in  WIDTH  source operand 1
- req_rs2  in  WIDTH  source operand 2
- req_pc  in  WIDTH  instruction PC
- req_imm  in  WIDTH  sign-extended immediate
- redirect_valid  out  1  redirect pending to fetch
- redirect_ready  in  1  fetch accepts redirect
- redirect_pc  out  WIDTH  new fetch PC
- link_addr  out  WIDTH  pc+4 of the accepted instruction, for rd writeback
- taken  out  1  last resolution outcome; holds until next resolution
- flush  out  1  one-cycle pulse: squash younger instructions
- done  out  1  one-cycle pulse: resolution complete
- misalign  out  1  one-cycle pulse: taken target misaligned
- illegal  out  1  one-cycle pulse: reserved op or funct3 010/011

Behaviour:
- Reset: all outputs 0, req_ready 1, FSM in IDLE.
  - Reset takes effect at any time; a mid-flight instruction is dropped with no done, no flush.
  - Registered state is cleared, including redirect_pc and link_addr.
- FSM states: IDLE, CMP, RESOLVE, REDIRECT. State encoding lives in the package.
- IDLE:
  - req_ready=1.
  - On req_valid at edge E0: capture all req_* fields and latch link_addr<=req_pc+4; go to CMP.
- CMP:
  - Comparator enabled for one cycle: eq, lt_signed, lt_unsigned registered at E1.
  - Target registered at E1, width-truncated with wraparound and no overflow flag:
    - branch/JAL: pc+imm
    - JALR: (rs1+imm) with bit 0 cleared
  - Go to RESOLVE.
- RESOLVE, decision at E2:
  - Condition per funct3: 000 eq; 001 !eq; 100 lt_s; 101 !lt_s; 110 lt_u; 111 !lt_u.
  - JAL and JALR are always taken.
  - Reserved op, or funct3 010/011 on a branch: illegal<=1, done<=1, taken<=0; go to IDLE.
  - Not taken: taken<=0, done<=1; go to IDLE.
  - Taken, target misaligned per IALIGN: taken<=1, misalign<=1, done<=1, no redirect; go to IDLE.
  - Taken, aligned: taken<=1, redirect_valid<=1, redirect_pc<=target; go to REDIRECT.
- REDIRECT:
  - redirect_valid and redirect_pc stay stable until redirect_ready is sampled high.
  - On that edge: redirect_valid<=0, flush<=1, done<=1; go to IDLE.
- Pulses (flush, done, misalign, illegal) are high for exactly one cycle.
- The done cycle coincides with IDLE, so req_ready=1 in that cycle and a back-to-back request is accepted there.
- req_valid while busy is ignored; the issuer must hold it.
- Latency from the accept edge:
  - Not-taken branch: done visible 2 cycles after accept.
  - Taken branch with redirect_ready held high: redirect_valid visible for 1 cycle, then flush/done.

Decomposition:
- Package branch_pkg:
  - op encodings (OP_BR, OP_JAL, OP_JALR)
  - funct3 constants (F3_BEQ … F3_BGEU)
  - FSM state localparams
- Sub-module branch_cmp: registered comparator with clk, rst, en and two operands.
  - Outputs eq, lt_s, lt_u; holds its outputs when en=0.
  - Instantiated once.

Test Plan:
- BEQ, rs1=rs2=0x0000_0010, pc=0x100, imm=0x20, redirect_ready=1 -> redirect_valid one cycle with redirect_pc=0x120, then flush=1, done=1, taken=1, link_addr=0x104.
- BLT vs BLTU, rs1=0xFFFF_FFFF, rs2=0x1: BLT -> taken, redirect; BLTU -> taken=0, done pulse 2 cycles after accept, no flush, no redirect_valid.
- JALR, rs1=0x203, imm=0x0, IALIGN=4 -> target 0x202, misalign=1, done=1, taken=1, redirect_valid never asserts.
- Taken BNE with redirect_ready held low 5 cycles -> redirect_valid and redirect_pc stable for 5 cycles, req_ready=0 throughout; flush fires the cycle after ready rises.
- funct3=010 on a branch -> illegal=1, done=1, taken=0; back-to-back JAL pc=0xFFFF_FFF0, imm=0x20 -> redirect_pc=0x0000_0010 (wraparound).
- Assert rst while in REDIRECT -> outputs 0 immediately (asynchronous), no flush/done; FSM in IDLE, req_ready=1 after release.
